// File: rtl/uart_pkg.sv
// Shared UART-side definitions: FSM state encoding, default frame width and a
// constant-safe clog2 helper usable in parameter expressions.
package uart_pkg;

  localparam int DBIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ARB       = 2'b00,
    LOAD      = 2'b01,
    WAIT_DONE = 2'b10,
    HOLD      = 2'b11
  } state_t;

  // Never returns less than 1 so a degenerate parameter still yields a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes plus the UART TX start/done handshake. The slave side is the
// arbiter; the master side is the requesters together with the UART TX.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DBIT  = DBIT_DEFAULT
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*DBIT-1:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      grant;
  logic                  tx_start;
  logic [DBIT-1:0]       tx_din;
  logic                  tx_done_tick;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, tx_done_tick,
    input  req_ready, grant, tx_start, tx_din, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_done_tick,
    output req_ready, grant, tx_start, tx_din, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid lane at or after i_ptr,
// wrapping modulo N. Kept generic for reuse by other shared-port arbiters.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic          o_hit,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  // Scan from the farthest offset down so the nearest hit to i_ptr wins last.
  always_comb begin : pick
    int c;
    o_hit = 1'b0;
    o_idx = '0;
    c     = 0;
    for (int j = N - 1; j >= 0; j--) begin
      c = int'(i_ptr) + j;
      if (c >= N) c = c - N;
      if (i_valid[c]) begin
        o_hit = 1'b1;
        o_idx = IW'(c);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_onehot[gi] = o_hit && (o_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter; a grant is kept for a whole
// message (until req_last) so multi-byte strings from different sources never mix.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DBIT     = DBIT_DEFAULT,
  parameter int HOLD_MAX = 1023
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = clog2(N_REQ);
  localparam int HW = clog2(HOLD_MAX + 1);

  state_t            r_state, w_state_next;
  logic [N_REQ-1:0]  r_grant, w_grant_next;
  logic [IW-1:0]     r_idx, w_idx_next;
  logic [IW-1:0]     r_ptr, w_ptr_next;
  logic              r_last, w_last_next;
  logic [HW-1:0]     r_hold, w_hold_next;
  logic              r_tx_start, w_tx_start_next;
  logic [DBIT-1:0]   r_tx_din, w_tx_din_next;
  logic              r_busy;

  logic              w_hit;
  logic [N_REQ-1:0]  w_onehot;
  logic [IW-1:0]     w_pick_idx;
  logic [IW-1:0]     w_idx_inc;
  logic [HW-1:0]     w_hold_inc;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_hit    (w_hit),
    .o_onehot (w_onehot),
    .o_idx    (w_pick_idx)
  );

  assign w_idx_inc  = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);
  assign w_hold_inc = (r_hold == '1) ? r_hold : r_hold + HW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_idx_next      = r_idx;
    w_ptr_next      = r_ptr;
    w_last_next     = r_last;
    w_hold_next     = r_hold;
    w_tx_start_next = 1'b0;
    w_tx_din_next   = r_tx_din;
    case (r_state)
      ARB: begin
        if (w_hit) begin
          w_state_next    = LOAD;
          w_grant_next    = w_onehot;
          w_idx_next      = w_pick_idx;
          w_tx_start_next = 1'b1;
          w_tx_din_next   = bus.req_data[int'(w_pick_idx)*DBIT +: DBIT];
        end
      end
      LOAD: begin
        w_last_next  = bus.req_last[r_idx];
        w_state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done_tick) begin
          if (r_last) begin
            w_grant_next = '0;
            w_ptr_next   = w_idx_inc;
            w_state_next = ARB;
          end else begin
            w_hold_next  = '0;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.req_valid[r_idx]) begin
          w_state_next    = LOAD;
          w_tx_start_next = 1'b1;
          w_tx_din_next   = bus.req_data[int'(r_idx)*DBIT +: DBIT];
        end else begin
          w_hold_next = w_hold_inc;
          // A stalled owner must not lock out the other sources forever.
          if (HOLD_MAX != 0 && w_hold_inc == HW'(HOLD_MAX)) begin
            w_grant_next = '0;
            w_ptr_next   = w_idx_inc;
            w_state_next = ARB;
          end
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB;
      r_grant    <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_last     <= 1'b0;
      r_hold     <= '0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_idx      <= w_idx_next;
      r_ptr      <= w_ptr_next;
      r_last     <= w_last_next;
      r_hold     <= w_hold_next;
      r_tx_start <= w_tx_start_next;
      r_tx_din   <= w_tx_din_next;
      r_busy     <= (w_state_next != ARB);
    end
  end

  assign bus.grant     = r_grant;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_din    = r_tx_din;
  assign bus.busy      = r_busy;
  assign bus.req_ready = (r_state == LOAD) ? r_grant : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two queued byte sources, a UART TX model
// answering each start after 10 cycles, and expected byte/grant orders.
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  logic man_tick;
  logic model_tick;
  int   ucnt;

  int   n_cmp;
  int   n_bad;
  int   rdy_cnt0;
  int   rdy_cnt1;
  int   rdy_bad;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] log_din[$];
  logic [1:0] log_gnt[$];

  localparam logic [7:0] T1_DIN [4] = '{8'h41, 8'h3A, 8'h35, 8'h0D};
  localparam logic [7:0] T2_DIN [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
  localparam logic [1:0] T2_GNT [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  localparam logic [7:0] T3_DIN [6] = '{8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h42};
  localparam logic [1:0] T3_GNT [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  uart_tx_arbiter_if #(.N_REQ(2), .DBIT(8)) bus ();

  uart_tx_arbiter #(.N_REQ(2), .DBIT(8), .HOLD_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // UART TX model: frame completes 10 cycles after the start pulse.
  always @(posedge clk or posedge reset) begin
    if (reset) ucnt <= 0;
    else if (bus.tx_start) ucnt <= 10;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign model_tick = (ucnt == 1);
  assign bus.tx_done_tick = model_tick | man_tick;

  // Requester sources: present queue head, pop after a seen ready pulse.
  initial begin
    logic [1:0] seen;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      seen = bus.req_ready;
      @(posedge clk);
      #1;
      if (seen[0] && q0.size() > 0) void'(q0.pop_front());
      if (seen[1] && q1.size() > 0) void'(q1.pop_front());
      bus.req_valid = {q1.size() > 0, q0.size() > 0};
      bus.req_data  = {(q1.size() > 0) ? q1[0][7:0] : 8'h00,
                       (q0.size() > 0) ? q0[0][7:0] : 8'h00};
      bus.req_last  = {(q1.size() > 0) ? q1[0][8] : 1'b0,
                       (q0.size() > 0) ? q0[0][8] : 1'b0};
    end
  end

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      log_din.push_back(bus.tx_din);
      log_gnt.push_back(bus.grant);
      $display("[%0t] tx_start din=0x%02h grant=%b", $time, bus.tx_din, bus.grant);
    end
    if (bus.req_ready[0] === 1'b1) rdy_cnt0++;
    if (bus.req_ready[1] === 1'b1) rdy_cnt1++;
    if ((bus.req_ready & ~bus.grant) != 2'b00) rdy_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish before 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_din.delete();
    log_gnt.delete();
    rdy_cnt0 = 0;
    rdy_cnt1 = 0;
    rdy_bad  = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && !(q0.size() == 0 && q1.size() == 0 &&
                           bus.busy === 1'b0 && bus.tx_start === 1'b0)) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (k < budget)
    else begin
      n_bad++;
      $error("FAIL %s: timeout observed %0d cycles expected < %0d", tag, k, budget);
    end
  endtask

  task automatic wait_tick(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && bus.tx_done_tick !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (k < budget)
    else begin
      n_bad++;
      $error("FAIL %s: timeout observed %0d cycles expected < %0d", tag, k, budget);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && bus.tx_start !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (k < budget)
    else begin
      n_bad++;
      $error("FAIL %s: timeout observed %0d cycles expected < %0d", tag, k, budget);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    man_tick = 1'b0;
    n_cmp    = 0;
    n_bad    = 0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst grant", 32'(bus.grant), 32'd0);
    chk("rst tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst tx_din", 32'(bus.tx_din), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst ptr", 32'(dut.r_ptr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester string "A:5\r"
    clear_logs();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h3A});
    q0.push_back({1'b0, 8'h35});
    q0.push_back({1'b1, 8'h0D});
    wait_idle("t1 idle", 200);
    chk("t1 starts", 32'(log_din.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1 din%0d", i), 32'(log_din[i]), 32'(T1_DIN[i]));
      chk($sformatf("t1 gnt%0d", i), 32'(log_gnt[i]), 32'b01);
    end
    chk("t1 ready0 pulses", 32'(rdy_cnt0), 32'd4);
    chk("t1 grant end", 32'(bus.grant), 32'd0);
    chk("t1 ptr end", 32'(dut.r_ptr), 32'd1);

    // Two 2-byte messages both pending from reset
    reset = 1'b1;
    q0.delete();
    q1.delete();
    q0.push_back({1'b0, 8'h10});
    q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b0, 8'h20});
    q1.push_back({1'b1, 8'h21});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    wait_idle("t2 idle", 300);
    chk("t2 starts", 32'(log_din.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2 din%0d", i), 32'(log_din[i]), 32'(T2_DIN[i]));
      chk($sformatf("t2 gnt%0d", i), 32'(log_gnt[i]), 32'(T2_GNT[i]));
    end
    chk("t2 ready outside grant", 32'(rdy_bad), 32'd0);
    chk("t2 ready1 pulses", 32'(rdy_cnt1), 32'd2);
    chk("t2 ptr end", 32'(dut.r_ptr), 32'd0);

    // Continuous 1-byte messages alternate
    clear_logs();
    q0.push_back({1'b1, 8'h30});
    q0.push_back({1'b1, 8'h31});
    q0.push_back({1'b1, 8'h32});
    q1.push_back({1'b1, 8'h40});
    q1.push_back({1'b1, 8'h41});
    q1.push_back({1'b1, 8'h42});
    wait_idle("t3 idle", 400);
    chk("t3 starts", 32'(log_din.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3 din%0d", i), 32'(log_din[i]), 32'(T3_DIN[i]));
      chk($sformatf("t3 gnt%0d", i), 32'(log_gnt[i]), 32'(T3_GNT[i]));
    end
    chk("t3 ptr end", 32'(dut.r_ptr), 32'd0);

    // Hold timeout: owner stalls after a non-last byte
    clear_logs();
    q0.push_back({1'b0, 8'h43});
    q1.push_back({1'b1, 8'h50});
    wait_tick("t4 first tick", 100);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) begin
        chk("t4 grant before release", 32'(bus.grant), 32'b01);
        chk("t4 ready1 held off", 32'(bus.req_ready), 32'd0);
      end
      if (k == 9) begin
        chk("t4 grant released", 32'(bus.grant), 32'd0);
        chk("t4 busy released", 32'(bus.busy), 32'd0);
      end
      if (k == 10) begin
        chk("t4 start req1", 32'(bus.tx_start), 32'd1);
        chk("t4 grant req1", 32'(bus.grant), 32'b10);
        chk("t4 din req1", 32'(bus.tx_din), 32'h50);
      end
    end
    wait_idle("t4 idle", 100);
    chk("t4 ptr end", 32'(dut.r_ptr), 32'd0);
    chk("t4 starts", 32'(log_din.size()), 32'd2);

    // Reset during WAIT_DONE, late tick afterwards
    q0.push_back({1'b0, 8'h60});
    q0.push_back({1'b1, 8'h61});
    wait_start("t5 start", 50);
    repeat (3) @(negedge clk);
    chk("t5 in wait_done", 32'(dut.r_state), 32'd2);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    chk("t5 grant", 32'(bus.grant), 32'd0);
    chk("t5 tx_din", 32'(bus.tx_din), 32'd0);
    chk("t5 busy", 32'(bus.busy), 32'd0);
    chk("t5 ptr", 32'(dut.r_ptr), 32'd0);
    repeat (2) @(negedge clk);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 state after tick", 32'(dut.r_state), 32'd0);
    chk("t5 busy after tick", 32'(bus.busy), 32'd0);
    chk("t5 no start", 32'(log_din.size()), 32'd0);

    // Spurious tick in ARB with the pointer parked at 1
    q0.push_back({1'b1, 8'h70});
    wait_idle("t6 idle", 100);
    chk("t6 ptr before", 32'(dut.r_ptr), 32'd1);
    clear_logs();
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 state", 32'(dut.r_state), 32'd0);
    chk("t6 busy", 32'(bus.busy), 32'd0);
    chk("t6 grant", 32'(bus.grant), 32'd0);
    chk("t6 ptr after", 32'(dut.r_ptr), 32'd1);
    chk("t6 no start", 32'(log_din.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between several byte sources (result formatter, command echo, status/error reporter) sitting in front of the BIP host link. Each requester offers bytes through a valid/ready handshake. A grant is held for a whole message, closed by `req_last`, so multi-byte strings such as "A:00123\r" are never interleaved. The block drives `tx_start`/`din` of the UART TX and consumes its `tx_done_tick`.

## Interface

- `N_REQ`, 2, number of requesters (2..8)
- `DBIT`, 8, data bits per UART frame
- `HOLD_MAX`, 1023, cycles a locked grant may wait for its owner's next byte before forced release; 0 disables the timeout
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  N_REQ  requester i has a byte on its data lane
- `req_data`  in  N_REQ*DBIT  lane i = bits [i*DBIT +: DBIT]
- `req_last`  in  N_REQ  byte on lane i is the final byte of its message
- `req_ready`  out  N_REQ  one-cycle acceptance pulse, one-hot or zero
- `grant`  out  N_REQ  one-hot owner of the transmitter, zero when free
- `tx_start`  out  1  one-cycle start pulse to the UART TX
- `tx_din`  out  DBIT  byte to the UART TX, stable from `tx_start` until the next load
- `tx_done_tick`  in  1  UART TX frame complete
- `busy`  out  1  high in every state except ARB

## Operation

- States: ARB, LOAD, WAIT_DONE, HOLD.
- ARB:
  - Search `req_valid` starting at pointer `ptr`, ascending modulo N_REQ.
  - First hit k: `grant` <= onehot(k), go to LOAD.
  - No hit: stay in ARB.
- LOAD (exactly one cycle):
  - `tx_start`=1, `req_ready[k]`=1, `tx_din` <= lane k.
  - Latch `last_q` <= `req_last[k]`.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for `tx_done_tick`.
  - On the tick: if `last_q`, then `grant` <= 0, `ptr` <= (k+1) mod N_REQ, go to ARB.
  - Otherwise clear the hold counter and go to HOLD.
- HOLD:
  - If `req_valid[k]`, go to LOAD (same owner).
  - Otherwise increment the hold counter. When it reaches HOLD_MAX (HOLD_MAX≠0), force release: `grant` <= 0, `ptr` <= k+1, go to ARB.
- Handshake: a transfer occurs only when valid and ready are both high. A requester holds `req_valid`, data and last stable until `req_ready`. Dropping valid before ready is allowed; that byte is simply not sent.
- Non-owner `req_valid` while granted is ignored; its ready stays 0.
- `tx_done_tick` outside WAIT_DONE is ignored. This covers a tick arriving from a frame in flight across reset.
- `req_last` of a non-owner has no effect.
- Reset values: all outputs 0, `tx_din`=0, `ptr`=0, `last_q`=0, hold counter 0, state ARB. Reset mid-message aborts the message with no resume; the requester must restart it.
- Hold counter width is clog2(HOLD_MAX+1) and it saturates.

## Timing

- `req_valid[k]` high at edge E0 in ARB → LOAD from E0. `tx_start` and `req_ready[k]` are high for E0→E1, and `tx_din` is valid from E0.
- Start latency is 1 cycle from ARB, and 1 cycle from HOLD.
- In-message byte gap: `tx_done_tick` at edge E → HOLD from E; valid sampled at E+1 → `tx_start` during E+1→E+2. The gap is 2 cycles plus the requester's own latency.
- `tx_done_tick` coincident with the LOAD cycle is ignored; the UART TX cannot finish a frame within one cycle.
- Grant changes only on state transitions, never combinationally from inputs.
- Every output is registered except the `req_ready` decode, which comes from state and `grant` only.

## Structure

- Shared package `uart_pkg`:
  - state encoding localparams (ARB=2'b00, LOAD=2'b01, WAIT_DONE=2'b10, HOLD=2'b11)
  - default DBIT
  - `clog2` function
- Sub-module `rr_pick`: combinational round-robin picker taking (`req_valid`, `ptr`) and returning (`hit`, one-hot, index). It is reused by a future BIP memory-port arbiter.
- The top level holds the FSM, `ptr`, `last_q`, hold counter and `tx_din` register.

## Test plan

- Single requester 0 sends 'A',':','5','\r', with last on '\r', and the UART model returns `tx_done_tick` 10 cycles after each start → 4 `tx_start` pulses, `tx_din` sequence 0x41,0x3A,0x35,0x0D, `grant`=01 throughout, then `grant`=00 and `ptr`=1.
- Req0 and req1 both valid from reset, 2-byte messages each → full order req0,req0,req1,req1. No interleave even though req1 stays valid; req1 ready never pulses while `grant`=01.
- Both requesters continuously valid with 1-byte messages, 6 messages → grants alternate 0,1,0,1,0,1.
- HOLD_MAX=8, req0 sends non-last 0x43 then drops valid, req1 valid → release 8 cycles after entering HOLD, then req1 is granted and `ptr` ends at 0 after req1's last byte.
- Reset asserted during WAIT_DONE, and `tx_done_tick` arrives 3 cycles after release → all outputs 0, tick ignored, state stays ARB with no `tx_start`.
- Spurious `tx_done_tick` in ARB with no valid → no state change, `busy`=0.
